// File: rtl/btn_hold_detect.sv
// Multi-channel button conditioner on the 32 kHz always-on clock: synchronise,
// debounce press/release, time long holds and emit short/long/release pulses.
module btn_hold_detect #(
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned CNT_W       = 9,
  parameter int unsigned DEB_CYC     = 32,
  parameter int unsigned LONG_CYC    = 511,
  parameter int unsigned ACTIVE_HIGH = 1
) (
  input  logic              i_clk_32k,
  input  logic              i_rst_n,
  input  logic [CH_NUM-1:0] i_btn,
  input  logic [CH_NUM-1:0] i_ch_en,
  output logic [CH_NUM-1:0] o_btn_level,
  output logic [CH_NUM-1:0] o_long_level,
  output logic [CH_NUM-1:0] o_short_pulse,
  output logic [CH_NUM-1:0] o_long_pulse,
  output logic [CH_NUM-1:0] o_rel_pulse
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DEB_P = 3'd1,
    S_HELD  = 3'd2,
    S_LONG  = 3'd3,
    S_DEB_R = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic             IDLE_PIN  = (ACTIVE_HIGH == 0) ? 1'b1 : 1'b0;

  logic [CH_NUM-1:0] r_sync1;
  logic [CH_NUM-1:0] r_sync2;
  logic [CH_NUM-1:0] w_pressed;

  // Two-flop synchroniser, reset to the released pin level
  always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= {CH_NUM{IDLE_PIN}};
      r_sync2 <= {CH_NUM{IDLE_PIN}};
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = r_sync2 ^ {CH_NUM{IDLE_PIN}};

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_from_long;
    logic             r_level;
    logic             r_long;
    logic             r_short;
    logic             r_longp;
    logic             r_rel;

    // Per-channel debounce / hold FSM; pulses default low every cycle
    always_ff @(posedge i_clk_32k or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state     <= S_IDLE;
        r_cnt       <= '0;
        r_from_long <= 1'b0;
        r_level     <= 1'b0;
        r_long      <= 1'b0;
        r_short     <= 1'b0;
        r_longp     <= 1'b0;
        r_rel       <= 1'b0;
      end else begin
        r_short <= 1'b0;
        r_longp <= 1'b0;
        r_rel   <= 1'b0;
        if (!i_ch_en[g]) begin
          r_state     <= S_IDLE;
          r_cnt       <= '0;
          r_from_long <= 1'b0;
          r_level     <= 1'b0;
          r_long      <= 1'b0;
        end else begin
          case (r_state)
            S_IDLE: begin
              if (w_pressed[g]) begin
                r_state <= S_DEB_P;
                r_cnt   <= CNT_ONE;
              end else begin
                r_cnt <= '0;
              end
            end
            S_DEB_P: begin
              if (!w_pressed[g]) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
              end else if (r_cnt == DEB_LAST) begin
                r_state <= S_HELD;
                r_cnt   <= '0;
                r_level <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_ONE;
              end
            end
            S_HELD: begin
              if (!w_pressed[g]) begin
                r_state     <= S_DEB_R;
                r_cnt       <= CNT_ONE;
                r_from_long <= 1'b0;
              end else if (r_cnt == LONG_LAST) begin
                r_state <= S_LONG;
                r_long  <= 1'b1;
                r_longp <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_ONE;
              end
            end
            S_LONG: begin
              if (!w_pressed[g]) begin
                r_state     <= S_DEB_R;
                r_cnt       <= CNT_ONE;
                r_from_long <= 1'b1;
              end
            end
            S_DEB_R: begin
              if (w_pressed[g]) begin
                // A bounce from a short hold restarts the long-hold timer
                if (r_from_long) begin
                  r_state <= S_LONG;
                end else begin
                  r_state <= S_HELD;
                  r_cnt   <= '0;
                end
              end else if (r_cnt == DEB_LAST) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_level <= 1'b0;
                r_long  <= 1'b0;
                r_rel   <= 1'b1;
                r_short <= ~r_from_long;
              end else begin
                r_cnt <= r_cnt + CNT_ONE;
              end
            end
            default: begin
              r_state <= S_IDLE;
              r_cnt   <= '0;
            end
          endcase
        end
      end
    end

    assign o_btn_level[g]   = r_level;
    assign o_long_level[g]  = r_long;
    assign o_short_pulse[g] = r_short;
    assign o_long_pulse[g]  = r_longp;
    assign o_rel_pulse[g]   = r_rel;
  end

endmodule
